// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between the ifu and decode.
// Holds up to DEPTH {pc, ir} pairs in a circular buffer with valid/ready
// handshakes on both sides. A flush (branch/jump redirect) discards every
// queued entry. While the queue is empty, decode sees a zero PC and a MIPS NOP.
//
// Optional build macro: FETCHQ_BYPASS_EN
//   When defined, an instruction that arrives while the queue is empty is
//   presented to decode in the same cycle. If decode takes it immediately,
//   it is never written to storage. When undefined, fetch-to-decode latency
//   is at least one cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   flush      in   redirect; clears the queue at the next edge
//   in_valid   in   ifu presents an instruction
//   in_pc      in   [31:0] PC of the fetched instruction
//   in_ir      in   [31:0] fetched instruction word
//   in_ready   out  queue can accept (not full); ifu stalls on !in_ready
//   out_valid  out  head entry valid toward decode
//   out_pc     out  [31:0] head PC, 0 when !out_valid
//   out_pc4    out  [31:0] out_pc + 4 (wraps mod 2^32)
//   out_ir     out  [31:0] head IR, 32'h0 (NOP) when !out_valid
//   out_ready  in   decode consumes the head entry
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_ir,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic [31:0] out_ir,
    input  logic        out_ready
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          bypass_take;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign in_ready = !full;

`ifdef FETCHQ_BYPASS_EN
    logic bypass_show;

    // The incoming instruction is visible to decode while storage is empty.
    assign bypass_show = empty && in_valid && !flush;
    assign bypass_take = bypass_show && out_ready;
    assign out_valid   = !empty || bypass_show;

    always_comb begin
        out_pc = 32'h0;
        out_ir = 32'h0;
        if (!empty) begin
            out_pc = mem[rd_ptr][63:32];
            out_ir = mem[rd_ptr][31:0];
        end else if (bypass_show) begin
            out_pc = in_pc;
            out_ir = in_ir;
        end
    end
`else
    assign bypass_take = 1'b0;
    assign out_valid   = !empty;

    // Zero-forcing keeps out_* defined even though storage is never reset.
    always_comb begin
        out_pc = 32'h0;
        out_ir = 32'h0;
        if (!empty) begin
            out_pc = mem[rd_ptr][63:32];
            out_ir = mem[rd_ptr][31:0];
        end
    end
`endif

    assign out_pc4 = out_pc + 32'd4;

    // A bypassed instruction consumed this cycle never enters storage, and
    // pops only ever come from storage.
    assign push = in_valid && in_ready && !flush && !bypass_take;
    assign pop  = !empty && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_pc, in_ir};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] IRX = 32'h8C00_0000;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_ir;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] out_ir;
    logic        out_ready;

    int n_checks = 0;
    int n_err    = 0;
    bit mon_en   = 0;

    logic [63:0] sb [$];

    fetch_queue #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_ir     (in_ir),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_pc4   (out_pc4),
        .out_ir    (out_ir),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs with the scoreboard head every cycle and
    // retires the head when decode consumes it.
    always @(negedge clk) begin
        logic [63:0] e;
        bit          ev;
        if (mon_en && reset) begin
            ev = (sb.size() != 0);
            e  = ev ? sb[0] : 64'h0;
`ifdef FETCHQ_BYPASS_EN
            if (!ev && in_valid && !flush) begin
                ev = 1'b1;
                e  = {in_pc, in_ir};
            end
`endif
            chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
            chk("in_ready", {31'b0, in_ready}, {31'b0, sb.size() != DEPTH});
            chk("out_pc", out_pc, e[63:32]);
            chk("out_ir", out_ir, e[31:0]);
            chk("out_pc4", out_pc4, e[63:32] + 32'd4);
            if (ev && out_ready && !flush && sb.size() != 0) begin
                void'(sb.pop_front());
            end
        end
    end

    // One clock of stimulus; the expected entry is queued after the monitor
    // has looked at this cycle, so it becomes visible one cycle later.
    task automatic step(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        bit wp;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_pc     = pc;
        in_ir     = pc ^ IRX;
        out_ready = rdy;
        flush     = fl;
        wp = v && !fl && (sb.size() < DEPTH);
`ifdef FETCHQ_BYPASS_EN
        if (sb.size() == 0 && v && !fl && rdy) wp = 1'b0;
`endif
        @(negedge clk);
        #1;
        if (fl) sb.delete();
        else if (wp) sb.push_back({pc, pc ^ IRX});
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_pc = '0; in_ir = '0; out_ready = 1'b0;
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_pc4", out_pc4, 32'd4);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        mon_en = 1'b1;

        // fill to full, fifth request ignored
        for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0);
        step(1'b1, 32'h10, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        // drain in order
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // steady push & pop with two entries, across the pointer wrap
        step(1'b1, 32'h100, 1'b0, 1'b0);
        step(1'b1, 32'h104, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h108 + 32'(i * 4), 1'b1, 1'b0);
            chk("count_steady", 32'(dut.count), 32'd2);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // flush with a same-cycle push and pop
        step(1'b1, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h204, 1'b0, 1'b0);
        step(1'b1, 32'h208, 1'b0, 1'b0);
        step(1'b1, 32'h40, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("count_flush", 32'(dut.count), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // PC+4 wrap and fetch-to-decode latency from empty
        step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_out_ir", out_ir, 32'd0);
        chk("mid_rst_out_pc4", out_pc4, 32'd4);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h400, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
